// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared tap constants and FSM encoding for the 3x3 convolution sequencer
package conv_seq_pkg;

    localparam int TAPS  = 9;
    localparam int TAP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/conv_3x3_wgt_rf.sv
// rtl/conv_3x3_wgt_rf.sv - 3x3 weight store, synchronous write, combinational read
module conv_3x3_wgt_rf #(
    parameter int DEPTH = conv_seq_pkg::TAPS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [conv_seq_pkg::TAP_W-1:0] waddr,
    input  logic [7:0]                    wdata,
    input  logic [conv_seq_pkg::TAP_W-1:0] raddr,
    output logic [7:0]                    rdata
);
    import conv_seq_pkg::*;

    logic [7:0] mem [DEPTH];

    // Out-of-range addresses match no entry, so such writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == TAP_W'(i)) mem[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == TAP_W'(i)) rdata = mem[i];
        end
    end

endmodule

// File: rtl/conv_3x3_seq.sv
// rtl/conv_3x3_seq.sv - 3x3 window sequencer feeding an external MAC (CONV_SEQ_LAST_CHECK_EN enables pix_last checking)
module conv_3x3_seq #(
    parameter int TAPS    = conv_seq_pkg::TAPS,
    parameter int MAC_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wgt_we,
    input  logic [3:0] wgt_addr,
    input  logic [7:0] wgt_wdata,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_data,
    input  logic       pix_last,
    output logic       mac_accum_clr,
    output logic [7:0] mac_data,
    output logic [7:0] mac_weight,
    input  logic [7:0] mac_ans,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       err_last
);
    import conv_seq_pkg::*;

    state_t           state, state_nxt;
    logic [TAP_W-1:0] tap_cnt;
    logic [7:0]       drain_cnt;
    logic [7:0]       rd_wgt;
    logic             accept;
    logic             last_tap;
    logic             drain_done;

    assign accept     = pix_valid & pix_ready;
    assign last_tap   = (tap_cnt == TAP_W'(TAPS - 1));
    assign drain_done = (drain_cnt == 8'(MAC_LAT));

    conv_3x3_wgt_rf #(
        .DEPTH (TAPS)
    ) u_wgt_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wgt_we),
        .waddr (wgt_addr),
        .wdata (wgt_wdata),
        .raddr (tap_cnt),
        .rdata (rd_wgt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                pix_ready = 1'b1;
                busy      = 1'b0;
                if (pix_valid) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                pix_ready = 1'b1;
                if (pix_valid && last_tap) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_valid && res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // MAC port carries zeros whenever no beat is accepted so the running sum is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt       <= '0;
            drain_cnt     <= '0;
            mac_accum_clr <= 1'b0;
            mac_data      <= '0;
            mac_weight    <= '0;
            res_data      <= '0;
            res_valid     <= 1'b0;
        end else begin
            mac_accum_clr <= accept && (tap_cnt == '0);
            mac_data      <= accept ? pix_data : '0;
            mac_weight    <= accept ? rd_wgt : '0;
            if (accept) tap_cnt <= last_tap ? '0 : tap_cnt + TAP_W'(1);
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 8'd1 : 8'd0;
            if (state == ST_DRAIN && drain_done) res_data <= mac_ans;
            res_valid <= (state == ST_HOLD) && !(res_valid && res_ready);
        end
    end

`ifdef CONV_SEQ_LAST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            err_last <= 1'b0;
        else if (accept && (pix_last != last_tap)) err_last <= 1'b1;
    end
`else
    logic unused_pix_last;
    assign unused_pix_last = pix_last;
    assign err_last        = 1'b0;
`endif

endmodule

// File: tb/tb_conv_3x3_seq.sv
// tb/tb_conv_3x3_seq.sv - directed bench with window-level reference model and MAC responder
module tb_conv_3x3_seq;

    localparam int MAC_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wgt_we;
    logic [3:0] wgt_addr;
    logic [7:0] wgt_wdata;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       pix_last;
    logic       mac_accum_clr;
    logic [7:0] mac_data;
    logic [7:0] mac_weight;
    logic [7:0] mac_ans = '0;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;
    logic       err_last;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit run_chk = 1'b0;

    conv_3x3_seq #(
        .TAPS    (9),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wgt_we        (wgt_we),
        .wgt_addr      (wgt_addr),
        .wgt_wdata     (wgt_wdata),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_last      (pix_last),
        .mac_accum_clr (mac_accum_clr),
        .mac_data      (mac_data),
        .mac_weight    (mac_weight),
        .mac_ans       (mac_ans),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy),
        .err_last      (err_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // MAC responder: accumulates on each tap, answer appears one register later.
    logic [19:0] mac_acc = '0;
    always @(posedge clk) begin
        logic [19:0] nxt;
        nxt = (mac_accum_clr ? 20'd0 : mac_acc) + 20'(mac_data) * 20'(mac_weight);
        #1;
        mac_ans = mac_acc[7:0];
        mac_acc = nxt;
    end

    // Window-level reference: per accepted beat, what appears on the MAC port next cycle,
    // and when the truncated dot product must be offered as a result.
    logic [7:0] m_wgt [9];
    int         m_count;
    bit         m_ready;
    int         m_wait;
    int         m_sum;
    logic [7:0] e_d, e_w, e_res;
    bit         e_clr, e_valid, e_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_wgt[i]) m_wgt[i] = '0;
            m_count = 0; m_ready = 1'b1; m_wait = 0; m_sum = 0;
            e_d = '0; e_w = '0; e_clr = 1'b0; e_valid = 1'b0; e_res = '0; e_err = 1'b0;
        end else begin
            bit acc;
            acc = pix_valid && m_ready;
            e_d = '0; e_w = '0; e_clr = 1'b0;
            if (e_valid && res_ready) begin
                e_valid = 1'b0;
                m_ready = 1'b1;
            end
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) e_valid = 1'b1;
            end
            if (acc) begin
`ifdef CONV_SEQ_LAST_CHECK_EN
                if (pix_last != (m_count == 8)) e_err = 1'b1;
`endif
                e_d   = pix_data;
                e_w   = m_wgt[m_count];
                e_clr = (m_count == 0);
                if (m_count == 0) m_sum = 0;
                m_sum += pix_data * m_wgt[m_count];
                m_count++;
                if (m_count == 9) begin
                    m_count = 0;
                    m_ready = 1'b0;
                    m_wait  = MAC_LAT + 2;
                    e_res   = m_sum[7:0];
                end
            end
            if (wgt_we && wgt_addr < 4'd9) m_wgt[wgt_addr] = wgt_wdata;
        end
    end

    always @(negedge clk) begin
        if (rst_n && run_chk) begin
            chk("mac_data", mac_data, e_d);
            chk("mac_weight", mac_weight, e_w);
            chk("mac_accum_clr", mac_accum_clr, e_clr);
            chk("pix_ready", pix_ready, m_ready);
            chk("busy", busy, (m_count != 0) || !m_ready);
            chk("res_valid", res_valid, e_valid);
            if (e_valid) chk("res_data", res_data, e_res);
            chk("err_last", err_last, e_err);
        end
    end

    task automatic wgt_write(input logic [3:0] a, input logic [7:0] d);
        wgt_we = 1'b1; wgt_addr = a; wgt_wdata = d;
        @(posedge clk); #1;
        wgt_we = 1'b0;
    endtask

    task automatic send_window(input logic [7:0] px [9], input int nbeats, input int bub_at,
                               input int bub_len, input int last_pos, output int t0);
        t0 = 0;
        for (int k = 0; k < nbeats; k++) begin
            int n;
            n = 0;
            pix_valid = 1'b1; pix_data = px[k]; pix_last = (k == last_pos);
            while (!pix_ready && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk); #1;
            if (k == 0) t0 = cyc;
            chk("beat_mac_data", mac_data, px[k]);
            chk("beat_accum_clr", mac_accum_clr, k == 0);
            pix_valid = 1'b0; pix_last = 1'b0; pix_data = '0;
            if (k == bub_at) begin
                repeat (bub_len) begin
                    @(posedge clk); #1;
                    chk("bubble_mac_data", mac_data, 0);
                    chk("bubble_mac_weight", mac_weight, 0);
                end
            end
        end
    endtask

    task automatic wait_res(input int hold, input logic [7:0] exp_lit, output int t_valid);
        int n;
        n = 0;
        res_ready = 1'b0;
        while (!res_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        t_valid = cyc;
        if (!res_valid) begin
            checks++; errors++;
            $display("FAIL res_timeout: res_valid never rose within 60 cycles");
        end else begin
            chk("res_data_lit", res_data, exp_lit);
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_res_data", res_data, exp_lit);
                chk("hold_res_valid", res_valid, 1);
                chk("hold_pix_ready", pix_ready, 0);
                chk("hold_busy", busy, 1);
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            chk("res_valid_drop", res_valid, 0);
            chk("idle_pix_ready", pix_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] px_up [9];
        logic [7:0] px_dn [9];
        logic [7:0] px_10 [9];
        int t0, tv;
        for (int i = 0; i < 9; i++) begin
            px_up[i] = 8'(i + 1);
            px_dn[i] = 8'(9 - i);
            px_10[i] = 8'd10;
        end
        rst_n = 1'b0; wgt_we = 1'b0; wgt_addr = '0; wgt_wdata = '0;
        pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_chk = 1'b1;

        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_mac_data", mac_data, 0);
        chk("rst_err_last", err_last, 0);

        // weights 1..9, pixels 1..9 back-to-back: sum of squares 285 -> 8'd29
        for (int i = 0; i < 9; i++) wgt_write(4'(i), 8'(i + 1));
        send_window(px_up, 9, -1, 0, 8, t0);
        wait_res(0, 8'd29, tv);
        chk("latency", tv - t0, 10 + MAC_LAT);
        chk("model_res_29", e_res, 29);

        // three bubbles after beat 4 leave the result unchanged
        send_window(px_up, 9, 3, 3, 8, t0);
        wait_res(0, 8'd29, tv);
        chk("bubble_latency", tv - t0, 13 + MAC_LAT);

        // pixels 9..1: sum k*(10-k) = 165, consumer stalls 5 cycles
        send_window(px_dn, 9, -1, 0, 8, t0);
        wait_res(5, 8'd165, tv);
        chk("model_res_165", e_res, 165);

        // reset mid-window clears everything, including weights
        send_window(px_up, 4, -1, 0, 8, t0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mac_data", mac_data, 0);
        chk("mid_rst_mac_weight", mac_weight, 0);
        chk("mid_rst_accum_clr", mac_accum_clr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_pix_ready", pix_ready, 1);
        // all pixels 10 against zeroed weights gives 0; then reload and expect 450 -> 8'd194
        send_window(px_10, 9, -1, 0, 8, t0);
        wait_res(0, 8'd0, tv);
        for (int i = 0; i < 9; i++) wgt_write(4'(i), 8'(i + 1));
        send_window(px_10, 9, -1, 0, 8, t0);
        wait_res(0, 8'd194, tv);

        // out-of-range weight write ignored; early pix_last only raises err_last
        wgt_write(4'd12, 8'hFF);
        send_window(px_up, 9, -1, 0, 4, t0);
        wait_res(0, 8'd29, tv);
`ifdef CONV_SEQ_LAST_CHECK_EN
        chk("err_last_lit", err_last, 1);
`else
        chk("err_last_lit", err_last, 0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
